instr_encoder_loader: RTL and testbench

Encodes a stream of instruction fields into 8-bit words for the custom 4-stage pipeline and writes them sequentially into instruction memory. It is the producer side of the pipeline's opcode decode: it builds the LI/SLL/J words that the control decode later consumes. The CPU is held in reset while a program loads, then released.

---
 rtl/instr_encoder_loader_if.sv | 34 +++
 rtl/instr_encoder_loader.sv | 108 ++++++++++
 tb/tb_instr_encoder_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Loader bus: control, instruction-field stream, memory write port and status.
// master = program source/host side, slave = the loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [2:0]        in_rd;
  logic [2:0]        in_src;
  logic [5:0]        in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal;
  logic              err_overflow;

  modport master (
    output start, in_valid, in_op, in_rd, in_src, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done,
           word_count, err_illegal, err_overflow
  );

  modport slave (
    input  start, in_valid, in_op, in_rd, in_src, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done,
           word_count, err_illegal, err_overflow
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes LI/SLL/J instruction fields into 8-bit words and writes them
// sequentially into instruction memory while holding the CPU in reset.
module instr_encoder_loader #(
  parameter int ADDR_W = 4
) (
  input logic                   clk,
  input logic                   reset,
  instr_encoder_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [1:0] OP_LI  = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_J   = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wdata_q;
  logic              err_illegal_q;
  logic              err_overflow_q;

  logic       accept;
  logic       legal;
  logic       at_top;
  logic       restart;
  logic [7:0] enc;

  assign accept  = (state_q == LOAD) && bus.in_valid;
  assign legal   = (bus.in_op != 2'b10);
  assign at_top  = (addr_q == '1);
  assign restart = bus.start && ((state_q == IDLE) || (state_q == DONE));

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    enc = '0;
    case (bus.in_op)
      OP_LI:   enc = {2'b00, bus.in_rd, bus.in_src};
      OP_SLL:  enc = {2'b01, bus.in_rd, bus.in_src};
      OP_J:    enc = {2'b11, bus.in_target};
      default: enc = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (accept && (bus.in_last || (legal && at_top))) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (bus.start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Write strobe is a one-cycle pulse one edge after the accept; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q         <= '0;
      count_q        <= '0;
      we_q           <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        addr_q         <= '0;
        count_q        <= '0;
        waddr_q        <= '0;
        err_illegal_q  <= 1'b0;
        err_overflow_q <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          we_q    <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= enc;
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
          if (at_top && !bus.in_last) err_overflow_q <= 1'b1;
        end else begin
          err_illegal_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = (state_q == LOAD);
  assign bus.cpu_hold     = (state_q != DONE);
  assign bus.done         = (state_q == DONE);
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = waddr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.word_count   = count_q;
  assign bus.err_illegal  = err_illegal_q;
  assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (ADDR_W = 4).
module tb_instr_encoder_loader;

  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } wr_t;

  wr_t log_q[$];

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) log_q.push_back('{bus.imem_addr, bus.imem_wdata, cyc});
  end

  task automatic set_fields(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] src,
                            input logic [5:0] tgt, input logic last);
    bus.in_op = op; bus.in_rd = rd; bus.in_src = src; bus.in_target = tgt; bus.in_last = last;
  endtask

  // Presents one instruction and returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] src,
                      input logic [5:0] tgt, input logic last);
    logic rdy;
    int   budget;
    set_fields(op, rd, src, tgt, last);
    bus.in_valid = 1'b1;
    budget = 20;
    rdy = 1'b0;
    while (!rdy && budget > 0) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      budget--;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready got 0 for 20 cycles, expected 1");
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] data);
    checks++;
    if (idx >= log_q.size()) begin
      failures++;
      $display("FAIL %s: write %0d missing (only %0d writes)", name, idx, log_q.size());
    end else if (log_q[idx].addr !== ADDR_W'(idx) || log_q[idx].data !== data) begin
      failures++;
      $display("FAIL %s: got 0x%02h@%0d expected 0x%02h@%0d", name, log_q[idx].data, log_q[idx].addr, data, idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
    set_fields(2'b00, 3'd0, 3'd0, 6'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done} !== 4'b0010) begin failures++; $display("FAIL reset_ctrl: ready/we/hold/done got %b expected 0010", {bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done}); end
    checks++; if (bus.imem_addr !== 4'd0 || bus.imem_wdata !== 8'h00 || bus.word_count !== 5'd0) begin failures++; $display("FAIL reset_data: addr=%0d wdata=0x%02h wc=%0d expected 0/0x00/0", bus.imem_addr, bus.imem_wdata, bus.word_count); end
    checks++; if ({bus.err_illegal, bus.err_overflow} !== 2'b00) begin failures++; $display("FAIL reset_err: got %b expected 00", {bus.err_illegal, bus.err_overflow}); end
    // in_valid while IDLE must be ignored.
    @(posedge clk); #1;
    log_q.delete();
    set_fields(2'b00, 3'd7, 3'd7, 6'd0, 1'b1);
    bus.in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (log_q.size() != 0 || bus.word_count !== 5'd0) begin failures++; $display("FAIL idle_valid_ignored: writes=%0d wc=%0d expected 0/0", log_q.size(), bus.word_count); end
    checks++; if ({bus.in_ready, bus.cpu_hold, bus.done} !== 3'b010) begin failures++; $display("FAIL idle_state: ready/hold/done got %b expected 010", {bus.in_ready, bus.cpu_hold, bus.done}); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    log_q.delete();
    do_start();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_start_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    send(2'b00, 3'd2, 3'd5, 6'd0, 1'b0);
    send(2'b01, 3'd3, 3'd1, 6'd0, 1'b0);
    send(2'b11, 3'd0, 3'd0, 6'h3A, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.imem_we, bus.in_ready, bus.done} !== 3'b100 || bus.imem_wdata !== 8'hFA) begin failures++; $display("FAIL basic_flush: we/ready/done=%b wdata=0x%02h expected 100/0xFA", {bus.imem_we, bus.in_ready, bus.done}, bus.imem_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({bus.done, bus.cpu_hold} !== 2'b10) begin failures++; $display("FAIL basic_done: done/hold got %b expected 10", {bus.done, bus.cpu_hold}); end
    checks++; if (bus.word_count !== 5'd3 || bus.imem_addr !== 4'd2) begin failures++; $display("FAIL basic_count: wc=%0d addr=%0d expected 3/2", bus.word_count, bus.imem_addr); end
    check_log("basic_w0", 0, 8'h15);
    check_log("basic_w1", 1, 8'h59);
    check_log("basic_w2", 2, 8'hFA);
    checks++; if (log_q.size() != 3 || log_q[1].cyc != log_q[0].cyc + 1 || log_q[2].cyc != log_q[1].cyc + 1) begin failures++; $display("FAIL basic_consecutive: writes=%0d not on consecutive cycles, expected 3 back-to-back", log_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    log_q.delete();
    do_start();
    send(2'b00, 3'd1, 3'd7, 6'd0, 1'b0);
    send(2'b10, 3'd5, 3'd5, 6'd0, 1'b0);
    send(2'b01, 3'd0, 3'd0, 6'd0, 1'b1);
    idle_cycles(2);
    @(negedge clk);
    checks++; if (log_q.size() != 2) begin failures++; $display("FAIL illegal_nwrites: got %0d expected 2", log_q.size()); end
    check_log("illegal_w0", 0, 8'h0F);
    check_log("illegal_w1", 1, 8'h40);
    checks++; if (bus.err_illegal !== 1'b1 || bus.err_overflow !== 1'b0 || bus.word_count !== 5'd2) begin failures++; $display("FAIL illegal_status: ill=%b ovf=%b wc=%0d expected 1/0/2", bus.err_illegal, bus.err_overflow, bus.word_count); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL illegal_done: got %b expected 1", bus.done); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [5:0] v;
    log_q.delete();
    do_start();
    for (int i = 0; i < 16; i++) begin
      v = 6'(i);
      send(2'b00, v[5:3], v[2:0], 6'd0, 1'b0);
    end
    // 17th word stays presented; it must never be taken.
    set_fields(2'b00, 3'd7, 3'd7, 6'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL overflow_ready_drop: got %b expected 0", bus.in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (log_q.size() != 16) begin failures++; $display("FAIL overflow_nwrites: got %0d expected 16", log_q.size()); end
    for (int i = 0; i < 16; i++) check_log("overflow_w", i, 8'(i));
    checks++; if (bus.err_overflow !== 1'b1 || bus.done !== 1'b1 || bus.word_count !== 5'd16) begin failures++; $display("FAIL overflow_status: ovf=%b done=%b wc=%0d expected 1/1/16", bus.err_overflow, bus.done, bus.word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_exact_fill();
    logic [5:0] v;
    log_q.delete();
    do_start();
    for (int i = 0; i < 16; i++) begin
      v = 6'(i);
      send(2'b00, v[5:3], v[2:0], 6'd0, i == 15);
    end
    idle_cycles(2);
    @(negedge clk);
    checks++; if (bus.err_overflow !== 1'b0 || bus.word_count !== 5'd16 || bus.done !== 1'b1) begin failures++; $display("FAIL exact_fill_status: ovf=%b wc=%0d done=%b expected 0/16/1", bus.err_overflow, bus.word_count, bus.done); end
    check_log("exact_fill_w15", 15, 8'h0F);
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    log_q.delete();
    do_start();
    set_fields(2'b00, 3'd4, 3'd2, 6'd0, 1'b0); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_fields(2'b11, 3'd0, 3'd0, 6'h3F, 1'b1); bus.in_valid = 1'b0;
    @(posedge clk); #1;
    set_fields(2'b01, 3'd5, 3'd6, 6'd0, 1'b0); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_fields(2'b11, 3'd0, 3'd0, 6'h2A, 1'b1); bus.in_valid = 1'b0;
    @(posedge clk); #1;
    send(2'b11, 3'd0, 3'd0, 6'h11, 1'b1);
    idle_cycles(2);
    @(negedge clk);
    checks++; if (log_q.size() != 3 || bus.word_count !== 5'd3) begin failures++; $display("FAIL gaps_nwrites: writes=%0d wc=%0d expected 3/3", log_q.size(), bus.word_count); end
    check_log("gaps_w0", 0, 8'h22);
    check_log("gaps_w1", 1, 8'h6E);
    check_log("gaps_w2", 2, 8'hD1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_reload();
    log_q.delete();
    do_start();
    send(2'b00, 3'd1, 3'd1, 6'd0, 1'b0);
    send(2'b00, 3'd1, 3'd2, 6'd0, 1'b0);
    // Third word is presented on the same edge that samples reset.
    set_fields(2'b00, 3'd1, 3'd3, 6'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done} !== 4'b0010 || bus.word_count !== 5'd0 || bus.imem_addr !== 4'd0 || bus.imem_wdata !== 8'h00) begin failures++; $display("FAIL midload_reset: ready/we/hold/done=%b wc=%0d addr=%0d wdata=0x%02h expected 0010/0/0/0x00", {bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done}, bus.word_count, bus.imem_addr, bus.imem_wdata); end
    idle_cycles(3);
    checks++; if (log_q.size() != 2) begin failures++; $display("FAIL midload_no_stray: writes=%0d expected 2", log_q.size()); end
    log_q.delete();
    do_start();
    send(2'b10, 3'd0, 3'd0, 6'd0, 1'b0);
    send(2'b11, 3'd0, 3'd0, 6'h05, 1'b1);
    idle_cycles(2);
    @(negedge clk);
    checks++; if (log_q.size() != 1 || bus.word_count !== 5'd1 || bus.err_illegal !== 1'b1 || bus.done !== 1'b1) begin failures++; $display("FAIL reload_status: writes=%0d wc=%0d ill=%b done=%b expected 1/1/1/1", log_q.size(), bus.word_count, bus.err_illegal, bus.done); end
    check_log("reload_w0", 0, 8'hC5);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    checks++; if ({bus.cpu_hold, bus.done, bus.in_ready} !== 3'b101 || bus.word_count !== 5'd0 || bus.err_illegal !== 1'b0) begin failures++; $display("FAIL restart_from_done: hold/done/ready=%b wc=%0d ill=%b expected 101/0/0", {bus.cpu_hold, bus.done, bus.in_ready}, bus.word_count, bus.err_illegal); end
    @(posedge clk); #1;
    send(2'b00, 3'd0, 3'd0, 6'd0, 1'b1);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_overflow();
    test_exact_fill();
    test_gaps();
    test_reset_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
